// File: rtl/ex_stage_if.sv
// Decode <-> execute bundle interface: the ID->EX bundle, pipeline control,
// the registered EX/MEM bundle and the operand-forwarding return path.
interface ex_stage_if #(
  parameter int DW  = 16,
  parameter int RW  = 3,
  parameter int EXW = 40,
  parameter int IDW = 57
);
  logic [IDW-1:0] id_bundle;
  logic           ex_flush;
  logic           mem_stall;
  logic [RW-1:0]  decoding_op_src1;
  logic [RW-1:0]  decoding_op_src2;
  logic [EXW-1:0] ex_mem_bundle;
  logic [DW-1:0]  fw_data1;
  logic [DW-1:0]  fw_data2;
  logic           forward_valid1;
  logic           forward_valid2;

  modport master (
    output id_bundle, ex_flush, mem_stall, decoding_op_src1, decoding_op_src2,
    input  ex_mem_bundle, fw_data1, fw_data2, forward_valid1, forward_valid2
  );

  modport slave (
    input  id_bundle, ex_flush, mem_stall, decoding_op_src1, decoding_op_src2,
    output ex_mem_bundle, fw_data1, fw_data2, forward_valid1, forward_valid2
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: ID/EX latch, 16-bit ALU / address adder, registered EX/MEM bundle.
// EX_FWD_EN adds the combinational operand-forwarding path back to decode.
module ex_stage #(
  parameter int DW  = 16,
  parameter int RW  = 3,
  parameter int EXW = 40
) (
  input  logic     clk,
  input  logic     rst,
  ex_stage_if.slave bus
);
  localparam int SHW = $clog2(DW);
  localparam int NSRC = 2;

  typedef struct packed {
    logic [2:0]    aluop;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          store;
    logic [DW-1:0] st_data;
    logic          wb_en;
    logic [RW-1:0] wb_reg;
    logic          wb_from_alu;
  } id_t;

  typedef struct packed {
    logic [DW-1:0] result;
    logic [DW-1:0] st_data;
    logic          mem_write;
    logic          mem_read;
    logic          wb_en;
    logic [RW-1:0] wb_reg;
    logic          wb_from_alu;
    logic          valid;
  } ex_t;

  id_t           idex_q;
  ex_t           ex_d, exmem_q;
  logic [DW-1:0] alu_res;

  // Flush beats stall so a killed instruction can never be replayed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                idex_q <= '0;
    else if (bus.ex_flush)  idex_q <= '0;
    else if (!bus.mem_stall) idex_q <= id_t'(bus.id_bundle);
  end

  always_comb begin
    alu_res = '0;
    unique case (idex_q.aluop)
      3'b000: alu_res = idex_q.op_a + idex_q.op_b;
      3'b001: alu_res = idex_q.op_a - idex_q.op_b;
      3'b010: alu_res = idex_q.op_a & idex_q.op_b;
      3'b011: alu_res = idex_q.op_a | idex_q.op_b;
      3'b100: alu_res = idex_q.op_a ^ idex_q.op_b;
      3'b101: alu_res = idex_q.op_a << idex_q.op_b[SHW-1:0];
      3'b110: alu_res = idex_q.op_a >> idex_q.op_b[SHW-1:0];
      3'b111: alu_res = {{(DW-1){1'b0}}, ($signed(idex_q.op_a) < $signed(idex_q.op_b))};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    ex_d             = '0;
    ex_d.result      = alu_res;
    ex_d.st_data     = idex_q.st_data;
    ex_d.mem_write   = idex_q.store;
    ex_d.mem_read    = idex_q.wb_en & ~idex_q.wb_from_alu;
    ex_d.wb_en       = idex_q.wb_en;
    ex_d.wb_reg      = idex_q.wb_reg;
    ex_d.wb_from_alu = idex_q.wb_from_alu;
    ex_d.valid       = |idex_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 exmem_q <= '0;
    else if (!bus.mem_stall) exmem_q <= ex_d;
  end

  assign bus.ex_mem_bundle = EXW'(exmem_q);

  logic [NSRC-1:0][RW-1:0] src;
  logic [NSRC-1:0][DW-1:0] fwd_data;
  logic [NSRC-1:0]         fwd_vld;

  assign src[0] = bus.decoding_op_src1;
  assign src[1] = bus.decoding_op_src2;

`ifdef EX_FWD_EN
  // Only ALU writers forward; loads resolve through decode's load-use stall.
  for (genvar s = 0; s < NSRC; s++) begin : g_fwd
    logic hit_ex, hit_mem;
    assign hit_ex  = idex_q.wb_en & idex_q.wb_from_alu & (idex_q.wb_reg == src[s]);
    assign hit_mem = exmem_q.wb_en & exmem_q.wb_from_alu & (exmem_q.wb_reg == src[s]);
    assign fwd_vld[s]  = (|src[s]) & (hit_ex | hit_mem);
    assign fwd_data[s] = !fwd_vld[s] ? '0 : hit_ex ? alu_res : exmem_q.result;
  end
`else
  logic unused_src;
  assign unused_src = ^src;
  assign fwd_vld    = '0;
  assign fwd_data   = '0;
`endif

  assign bus.forward_valid1 = fwd_vld[0];
  assign bus.forward_valid2 = fwd_vld[1];
  assign bus.fw_data1       = fwd_data[0];
  assign bus.fw_data2       = fwd_data[1];
endmodule
